ysyx_220066_muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the EX stage. It accepts one RV64M operation whenever EX decodes a muldiv op (ALUctr[5] set) and runs a radix-2 shift-add multiplier or restoring divider over 32 or 64 cycles. It resolves divide-by-zero and signed overflow without iterating, and holds the result until EX consumes it. While an operation is in flight, `busy` feeds the EX/pipeline `block` chain.

---
 rtl/ysyx_220066_muldiv_pkg.sv | 32 +++
 rtl/ysyx_220066_muldiv_core.sv | 69 ++++++
 rtl/ysyx_220066_muldiv_seq.sv | 186 ++++++++++++++++++
 tb/tb_ysyx_220066_muldiv_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220066_muldiv_pkg.sv
// rtl/ysyx_220066_muldiv_pkg.sv - shared op codes, state encoding and iteration counts for the muldiv sequencer
package ysyx_220066_muldiv_pkg;

    // RV funct3 encodings of the M-extension ops
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned ITER_W = 32;
    localparam int unsigned ITER_D = 64;

    // The down-counter starts at N-1 so that counter==0 marks the last step
    localparam logic [5:0] CNT_W_INIT = 6'(ITER_W - 1);
    localparam logic [5:0] CNT_D_INIT = 6'(ITER_D - 1);

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_220066_muldiv_core.sv
// rtl/ysyx_220066_muldiv_core.sv - radix-2 shift-add multiply / restoring divide datapath
module ysyx_220066_muldiv_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic         is_mul,
    input  logic         is_w,
    input  logic [63:0]  mag1,
    input  logic [63:0]  mag2,
    output logic [127:0] acc
);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
    logic [127:0] acc_q, acc_d;
    logic [63:0]  opd_q, opd_d;
    logic         is_mul_q, is_mul_d;

    logic [64:0]  sum;
    logic [64:0]  shifted;
    logic [63:0]  diff;
    logic         ge;

    // One datapath step per cycle; load aligns the operands for the chosen op
    always_comb begin
        sum      = {1'b0, acc_q[127:64]} + {1'b0, (acc_q[0] ? opd_q : 64'd0)};
        shifted  = {acc_q[127:64], acc_q[63]};
        ge       = (shifted >= {1'b0, opd_q});
        // Only used when ge, where the true difference is below the divisor
        diff     = shifted[63:0] - opd_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_mul_d = is_mul_q;
        if (load) begin
            is_mul_d = is_mul;
            if (is_mul) begin
                acc_d = {64'd0, mag2};
                opd_d = mag1;
            end else begin
                // W divides top-align the 32-bit dividend so 32 steps consume it
                acc_d = {64'd0, (is_w ? {mag1[31:0], 32'd0} : mag1)};
                opd_d = mag2;
            end
        end else if (step) begin
            if (is_mul_q) begin
                acc_d = {sum, acc_q[63:1]};
            end else begin
                acc_d = {(ge ? diff : shifted[63:0]), acc_q[62:0], ge};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            opd_q    <= '0;
            is_mul_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_mul_q <= is_mul_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/ysyx_220066_muldiv_seq.sv
// rtl/ysyx_220066_muldiv_seq.sv - EX-stage muldiv sequencer FSM with operand prep and result fix-up
module ysyx_220066_muldiv_seq
    import ysyx_220066_muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [2:0]      op,
    input  logic            is_w,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            div_zero,
    output logic            busy
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        is_w_q, is_w_d;
    logic        neg_q, neg_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] result_q, result_d;
    logic        div_zero_q, div_zero_d;

    logic        core_load, core_step;
    logic [127:0] acc;

    logic        is_div, sgn_div, s1_signed, s2_signed, neg1, neg2;
    logic        dz, ovf, special, res_neg;
    logic [63:0] opa, opb, mag1, mag2, spec_raw, spec_val;

    // Operand prep at accept: W-divide extension, magnitudes, result sign, special divides
    always_comb begin
        is_div  = op[2];
        sgn_div = is_div & ~op[0];
        opa     = src1;
        opb     = src2;
        if (is_div && is_w) begin
            opa = sgn_div ? sext32(src1[31:0]) : {32'd0, src1[31:0]};
            opb = sgn_div ? sext32(src2[31:0]) : {32'd0, src2[31:0]};
        end
        s1_signed = (op == OP_MULH) | (op == OP_MULHSU) | sgn_div;
        s2_signed = (op == OP_MULH) | sgn_div;
        neg1      = s1_signed & opa[63];
        neg2      = s2_signed & opb[63];
        mag1      = neg1 ? (~opa + 64'd1) : opa;
        mag2      = neg2 ? (~opb + 64'd1) : opb;
        // Remainder follows the dividend sign; everything else is the xor
        res_neg   = (is_div & op[1]) ? neg1 : (neg1 ^ neg2);
        dz        = is_div & (opb == 64'd0);
        ovf       = sgn_div & (opb == 64'hFFFF_FFFF_FFFF_FFFF)
                  & (opa == (is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special   = dz | ovf;
        if (op[1]) begin
            spec_raw = dz ? opa : 64'd0;
        end else begin
            spec_raw = dz ? 64'hFFFF_FFFF_FFFF_FFFF : opa;
        end
        spec_val  = is_w ? sext32(spec_raw[31:0]) : spec_raw;
    end

    logic [63:0] acc_hi, acc_lo, fix_pre, fix_val;

    // Sign correction and output selection from the finished accumulator
    always_comb begin
        acc_hi = acc[127:64];
        acc_lo = acc[63:0];
        case (op_q)
            // After 32 steps a W product's low word sits in acc[63:32]
            OP_MUL:    fix_pre = is_w_q ? {32'd0, acc[63:32]} : acc_lo;
            // High half of a 128-bit negate: ~hi plus the carry out of ~lo+1
            OP_MULH, OP_MULHSU, OP_MULHU:
                       fix_pre = neg_q ? (~acc_hi + {63'd0, (acc_lo == 64'd0)}) : acc_hi;
            OP_DIV, OP_DIVU:
                       fix_pre = neg_q ? (~acc_lo + 64'd1) : acc_lo;
            default:   fix_pre = neg_q ? (~acc_hi + 64'd1) : acc_hi;
        endcase
        fix_val = is_w_q ? sext32(fix_pre[31:0]) : fix_pre;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        is_w_d       = is_w_q;
        neg_d        = neg_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        div_zero_d   = div_zero_q;
        core_load    = 1'b0;
        core_step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    op_d   = op;
                    is_w_d = is_w;
                    neg_d  = res_neg;
                    if (special) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        result_d     = spec_val;
                        div_zero_d   = dz;
                    end else begin
                        state_d   = ST_CALC;
                        core_load = 1'b1;
                        cnt_d     = is_w ? CNT_W_INIT : CNT_D_INIT;
                    end
                end
            end
            ST_CALC: begin
                core_step = 1'b1;
                if (cnt_q == 6'd0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_FIX: begin
                state_d      = ST_DONE;
                resp_valid_d = 1'b1;
                result_d     = fix_val;
                div_zero_d   = 1'b0;
            end
            default: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
        endcase
        if (flush) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
        end
    end

    // Sequencer state and registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            is_w_q       <= 1'b0;
            neg_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            is_w_q       <= is_w_d;
            neg_q        <= neg_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            div_zero_q   <= div_zero_d;
        end
    end

    ysyx_220066_muldiv_core u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (core_load),
        .step   (core_step),
        .is_mul (~op[2]),
        .is_w   (is_w),
        .mag1   (mag1),
        .mag2   (mag2),
        .acc    (acc)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign result     = result_q;
    assign div_zero   = div_zero_q;

endmodule

// File: tb/tb_ysyx_220066_muldiv_seq.sv
// tb/tb_ysyx_220066_muldiv_seq.sv - randomized self-checking bench for the muldiv sequencer
module tb_ysyx_220066_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic [2:0]  op = '0;
    logic        is_w = 1'b0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] result;
    logic        div_zero;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_220066_muldiv_seq #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .src1       (src1),
        .src2       (src2),
        .op         (op),
        .is_w       (is_w),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .div_zero   (div_zero),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Architectural RV64M result, computed with plain wide arithmetic
    function automatic void model(input logic [2:0] o, input bit w, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic dz, output int lat);
        logic signed [127:0] pa, pb;
        logic [127:0]        prod;
        logic signed [63:0]  sa, sb;
        logic signed [31:0]  sa32, sb32;
        logic [31:0]         r32;
        dz  = 1'b0;
        lat = w ? 34 : 66;
        r   = '0;
        case (o)
            3'd0: begin
                prod = {64'd0, a} * {64'd0, b};
                r = w ? sx32(prod[31:0]) : prod[63:0];
            end
            3'd1: begin
                pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b};
                prod = pa * pb; r = prod[127:64];
            end
            3'd2: begin
                pa = {{64{a[63]}}, a}; pb = {64'd0, b};
                prod = pa * pb; r = prod[127:64];
            end
            3'd3: begin
                prod = {64'd0, a} * {64'd0, b}; r = prod[127:64];
            end
            default: begin
                if (w) begin
                    if (!o[0]) begin
                        sa32 = a[31:0]; sb32 = b[31:0];
                        if (sb32 == 0) begin
                            dz = 1'b1; lat = 1; r32 = o[1] ? a[31:0] : 32'hFFFF_FFFF;
                        end else if (sa32 == 32'sh8000_0000 && sb32 == -1) begin
                            lat = 1; r32 = o[1] ? 32'd0 : a[31:0];
                        end else begin
                            r32 = o[1] ? (sa32 % sb32) : (sa32 / sb32);
                        end
                    end else begin
                        if (b[31:0] == 0) begin
                            dz = 1'b1; lat = 1; r32 = o[1] ? a[31:0] : 32'hFFFF_FFFF;
                        end else begin
                            r32 = o[1] ? (a[31:0] % b[31:0]) : (a[31:0] / b[31:0]);
                        end
                    end
                    r = sx32(r32);
                end else begin
                    sa = a; sb = b;
                    if (b == 0) begin
                        dz = 1'b1; lat = 1; r = o[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
                    end else if (!o[0] && a == 64'h8000_0000_0000_0000 && sb == -1) begin
                        lat = 1; r = o[1] ? 64'd0 : a;
                    end else if (!o[0]) begin
                        r = o[1] ? (sa % sb) : (sa / sb);
                    end else begin
                        r = o[1] ? (a % b) : (a / b);
                    end
                end
            end
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input bit w, input logic [63:0] a, input logic [63:0] b,
                         input int hold, output logic [63:0] got);
        logic [63:0] er;
        logic        edz;
        int          elat;
        int          lat;
        model(o, w, a, b, er, edz, elat);
        @(negedge clk);
        req_valid = 1'b1; op = o; is_w = w; src1 = a; src2 = b; resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency op%0d w%0d", o, w), 64'(lat), 64'(elat));
        chk($sformatf("result op%0d w%0d a=%h b=%h", o, w, a, b), result, er);
        chk("div_zero", {63'd0, div_zero}, {63'd0, edz});
        chk("busy_in_done", {63'd0, busy}, 64'd1);
        got = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_result", result, er);
            chk("hold_valid", {63'd0, resp_valid}, 64'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("busy_after_hs", {63'd0, busy}, 64'd0);
        chk("ready_after_hs", {63'd0, req_ready}, 64'd1);
        chk("valid_after_hs", {63'd0, resp_valid}, 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] got;
        int          rises;
        logic [2:0]  ro;
        bit          rw;
        logic [63:0] ra, rb;
        int          sel;

        repeat (3) @(negedge clk);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_div_zero", {63'd0, div_zero}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        rst = 1'b0;

        do_op(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, got);
        chk("tp_mul", got, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(3'd3, 1'b0, '1, '1, 0, got);
        chk("tp_mulhu", got, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(3'd5, 1'b0, 64'h1234, 64'd0, 0, got);
        chk("tp_divu0", got, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(3'd7, 1'b0, 64'h1234, 64'd0, 0, got);
        chk("tp_remu0", got, 64'h1234);
        do_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0, got);
        chk("tp_div_ovf", got, 64'h8000_0000_0000_0000);
        do_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 0, got);
        chk("tp_rem_ovf", got, 64'd0);
        do_op(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0, got);
        chk("tp_divw", got, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5, got);
        chk("tp_remw", got, 64'hFFFF_FFFF_FFFF_FFFF);

        // Flush ten cycles into CALC
        @(negedge clk);
        req_valid = 1'b1; op = 3'd0; is_w = 1'b0; src1 = 64'd11; src2 = 64'd13;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_ready", {63'd0, req_ready}, 64'd1);
        rises = 0;
        repeat (80) begin
            @(negedge clk);
            if (resp_valid) rises++;
        end
        chk("flush_no_resp", 64'(rises), 64'd0);
        do_op(3'd0, 1'b0, 64'd6, 64'd7, 0, got);
        chk("tp_mul_after_flush", got, 64'd42);

        // Flush coinciding with a request suppresses the accept
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; op = 3'd5; src1 = 64'd5; src2 = 64'd0;
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_accept_busy", {63'd0, busy}, 64'd0);
        chk("flush_accept_valid", {63'd0, resp_valid}, 64'd0);

        // Asynchronous reset mid-CALC clears outputs with no clock edge
        @(negedge clk);
        req_valid = 1'b1; op = 3'd5; is_w = 1'b0; src1 = 64'd100; src2 = 64'd7;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_ready", {63'd0, req_ready}, 64'd1);
        chk("arst_result", result, 64'd0);
        chk("arst_valid", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 30; k++) begin
            ro  = 3'($urandom_range(0, 7));
            rw  = (ro == 3'd1 || ro == 3'd2 || ro == 3'd3) ? 1'b0 : 1'($urandom_range(0, 1));
            ra  = {$urandom, $urandom};
            sel = $urandom_range(0, 5);
            case (sel)
                0: rb = 64'd0;
                1: begin
                    rb = '1;
                    ra = rw ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
                end
                2: rb = 64'($urandom_range(1, 100));
                3: begin
                    rb = {$urandom, $urandom};
                    ra = -ra;
                end
                default: rb = {$urandom, $urandom};
            endcase
            do_op(ro, rw, ra, rb, $urandom_range(0, 3), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
